// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo CDB slice: schedule, broadcast and tag/data types,
// plus the round-robin find-first used by the CDB arbiter and the reservation station.
package tomasulo_pkg;

  localparam int unsigned LAT_MAX = 4;
  localparam int unsigned SCH_W   = LAT_MAX + 3;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned RR_MAX  = 8;
  localparam int unsigned RR_IW   = $clog2(RR_MAX);

  typedef logic [SCH_W-1:0]  sch_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic  vld;
    tag_t  tag;
    word_t wdata;
  } cdb_t;

  typedef struct packed {
    logic             found;
    logic [RR_IW-1:0] idx;
  } rr_t;

  // First set bit of req[n-1:0], scanning upward from ptr and wrapping at n.
  function automatic rr_t ffs_rr(input logic [RR_MAX-1:0] req,
                                 input int unsigned n,
                                 input int unsigned ptr);
    rr_t         r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      if (i < n) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        if (!r.found && req[j[RR_IW-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[RR_IW-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tomasulo_cdb_arb.sv
// K-way round-robin arbiter: at most one grant per cycle, pointer moves past the winner.
module tomasulo_cdb_arb
  import tomasulo_pkg::*;
#(
  parameter int unsigned K = 3,
  localparam int unsigned PW = (K > 1) ? $clog2(K) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] req,
  output logic [K-1:0] gnt
);

  logic [PW-1:0]     rr_ptr_r;
  logic [RR_MAX-1:0] req_x;
  rr_t               pick;
  int unsigned       nxt;

  always_comb begin
    req_x          = '0;
    req_x[K-1:0]   = req;
    pick           = ffs_rr(req_x, K, 32'(rr_ptr_r));
    nxt            = 32'(pick.idx) + 1;
    if (nxt >= K) nxt = 0;
    gnt = '0;
    for (int unsigned k = 0; k < K; k++)
      gnt[k] = rst_n && pick.found && (32'(pick.idx) == k);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rr_ptr_r <= '0;
    else if (pick.found)
      rr_ptr_r <= PW'(nxt);
  end

endmodule

// File: rtl/tomasulo_cdb.sv
// Common Data Bus controller: reserves future CDB slots for granted requesters and
// registers the single-cycle writeback broadcast, flagging schedule/writeback disagreement.
module tomasulo_cdb
  import tomasulo_pkg::*;
#(
  parameter int unsigned K = 3,
  parameter int unsigned LAT [K] = '{2, 2, 4}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [K-1:0]        cdb_req,
  output logic [K-1:0]        cdb_gnt,
  output sch_t                sch_r,
  input  logic [K-1:0]        wb_vld,
  input  tag_t  [K-1:0]       wb_tag,
  input  word_t [K-1:0]       wb_wdata,
  output cdb_t                cdb_r,
  output logic                err_r
);

  logic [K-1:0] elig;
  sch_t         sch_w;
  cdb_t         cdb_w;
  logic         found;
  logic         wb_any;
  logic         wb_multi;
  logic         err_w;
  logic         fresh_r;

  tomasulo_cdb_arb #(.K(K)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (elig),
    .gnt   (cdb_gnt)
  );

  // A requester may only be granted if the slot its result will land in is free.
  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < K; k++)
      elig[k] = cdb_req[k] && ((sch_r & (sch_t'(1) << (LAT[k] + 2))) == '0);
  end

  always_comb begin
    sch_w = sch_r >> 1;
    for (int unsigned k = 0; k < K; k++)
      if (cdb_gnt[k]) sch_w = sch_w | (sch_t'(1) << (LAT[k] + 1));
  end

  always_comb begin
    cdb_w     = cdb_r;
    cdb_w.vld = 1'b0;
    found     = 1'b0;
    for (int unsigned k = 0; k < K; k++) begin
      if (wb_vld[k] && !found) begin
        found = 1'b1;
        cdb_w = '{vld: 1'b1, tag: wb_tag[k], wdata: wb_wdata[k]};
      end
    end
    // The cycle right after reset release carries no broadcast; a stray writeback
    // there is only reported through err_r.
    if (!fresh_r) cdb_w = '{vld: 1'b0, tag: cdb_r.tag, wdata: cdb_r.wdata};
  end

  always_comb begin
    wb_any   = |wb_vld;
    wb_multi = (wb_vld & (wb_vld - K'(1))) != '0;
    err_w    = err_r | wb_multi | (wb_any & ~sch_r[1]) | (sch_r[1] & ~wb_any);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sch_r   <= '0;
      cdb_r   <= '0;
      err_r   <= 1'b0;
      fresh_r <= 1'b0;
    end else begin
      sch_r   <= sch_w;
      cdb_r   <= cdb_w;
      err_r   <= err_w;
      fresh_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tomasulo_cdb.sv
// Scoreboard bench for tomasulo_cdb: stimulus models slot reservations by absolute cycle,
// a separate monitor checks the registered broadcast, schedule and error flag.
module tb_tomasulo_cdb;
  import tomasulo_pkg::*;

  localparam int unsigned K = 3;
  localparam int unsigned LAT [K] = '{2, 2, 4};
  localparam int N = 8192;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [K-1:0] cdb_req = '0;
  logic [K-1:0] cdb_gnt;
  logic [K-1:0] wb_vld = '0;
  tag_t  [K-1:0] wb_tag = '0;
  word_t [K-1:0] wb_wdata = '0;
  sch_t         sch_r;
  cdb_t         cdb_r;
  logic         err_r;

  tomasulo_cdb #(.K(K), .LAT(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cdb_req  (cdb_req),
    .cdb_gnt  (cdb_gnt),
    .sch_r    (sch_r),
    .wb_vld   (wb_vld),
    .wb_tag   (wb_tag),
    .wb_wdata (wb_wdata),
    .cdb_r    (cdb_r),
    .err_r    (err_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model indexed by absolute cycle number.
  bit    busy    [N];   // CDB broadcast slot reserved for this cycle
  bit    has_wb  [N];   // a unit owes a writeback in this cycle
  int    wb_k    [N];
  tag_t  wb_t    [N];
  word_t wb_d    [N];
  bit    err_at  [N];   // expected err_r during this cycle
  bit    fresh_at[N];   // first cycle after reset release

  typedef struct {
    int    due;
    tag_t  tag;
    word_t wdata;
  } exp_t;
  exp_t exp_q[$];

  int rr = 0;
  bit mon_en = 1'b0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  task automatic step(input logic rst, input logic [K-1:0] req, input bit drop,
                      input logic [K-1:0] extra);
    int           c;
    int           g;
    int           n;
    int           kk;
    bit           res;
    logic [K-1:0] v;
    logic [K-1:0] eg;
    @(negedge clk);
    c       = cyc;
    rst_n   = rst;
    cdb_req = req;
    v       = '0;
    for (int k = 0; k < K; k++) begin
      wb_tag[k]   = tag_t'($urandom);
      wb_wdata[k] = $urandom;
    end
    if (has_wb[c] && !drop) begin
      v[wb_k[c]]        = 1'b1;
      wb_tag[wb_k[c]]   = wb_t[c];
      wb_wdata[wb_k[c]] = wb_d[c];
    end
    has_wb[c] = 1'b0;
    for (int k = 0; k < K; k++)
      if (extra[k]) begin
        v[k]      = 1'b1;
        wb_tag[k] = tag_t'(5 + k);
      end
    wb_vld = v;
    #1;
    g = -1;
    if (rst)
      for (int i = 0; i < K; i++) begin
        kk = (rr + i) % K;
        if (g < 0 && req[kk] && !busy[c + LAT[kk] + 2]) g = kk;
      end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("gnt", 64'(cdb_gnt), 64'(eg));
    if (!rst) begin
      rr = 0;
      for (int j = 1; j <= SCH_W + 1; j++) begin
        busy[c + j]   = 1'b0;
        has_wb[c + j] = 1'b0;
      end
      exp_q.delete();
      err_at[c + 1]   = 1'b0;
      fresh_at[c + 1] = 1'b1;
    end else begin
      if (g >= 0) begin
        busy[c + LAT[g] + 2]   = 1'b1;
        has_wb[c + LAT[g] + 1] = 1'b1;
        wb_k[c + LAT[g] + 1]   = g;
        wb_t[c + LAT[g] + 1]   = tag_t'($urandom);
        wb_d[c + LAT[g] + 1]   = $urandom;
        rr = (g + 1) % K;
      end
      res = busy[c + 1];
      n   = $countones(v);
      err_at[c + 1]   = err_at[c] || (n > 1) || (n > 0 && !res) || (res && n == 0);
      fresh_at[c + 1] = 1'b0;
      if (n > 0 && !fresh_at[c]) begin
        kk = -1;
        for (int k = K - 1; k >= 0; k--) if (v[k]) kk = k;
        exp_q.push_back('{due: c + 1, tag: wb_tag[kk], wdata: wb_wdata[kk]});
      end
    end
  endtask

  // Monitor: compares registered outputs against the model after every active edge.
  initial begin
    sch_t es;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (mon_en) begin
        for (int j = 0; j < SCH_W; j++) es[j] = busy[cyc + j];
        check("sch", 64'(sch_r), 64'(es));
        check("err", 64'(err_r), 64'(err_at[cyc]));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          check("cdb_vld", 64'(cdb_r.vld), 64'(1));
          check("cdb_tag", 64'(cdb_r.tag), 64'(e.tag));
          check("cdb_wdata", 64'(cdb_r.wdata), 64'(e.wdata));
        end else begin
          check("cdb_vld", 64'(cdb_r.vld), 64'(0));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    int r;
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '1, 1'b0, '0);
    mon_en = 1'b1;
    step(1'b1, 3'b111, 1'b0, '0);
    repeat (12) step(1'b1, 3'b011, 1'b0, '0);
    repeat (8)  step(1'b1, '0, 1'b0, '0);
    // requester 2 takes a slot that requester 0 then collides with
    step(1'b1, 3'b100, 1'b0, '0);
    step(1'b1, '0, 1'b0, '0);
    step(1'b1, 3'b001, 1'b0, '0);
    step(1'b1, 3'b001, 1'b0, '0);
    repeat (8)  step(1'b1, '0, 1'b0, '0);
    // two simultaneous writebacks
    step(1'b1, '0, 1'b0, 3'b011);
    repeat (3)  step(1'b1, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    // reserved slot with its writeback withheld
    step(1'b1, 3'b001, 1'b0, '0);
    repeat (6)  step(1'b1, '0, 1'b1, '0);
    step(1'b0, '0, 1'b0, '0);
    step(1'b1, '0, 1'b0, '0);
    // reset with reservations in flight, then a stray writeback right after release
    step(1'b1, 3'b111, 1'b0, '0);
    step(1'b1, 3'b111, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    step(1'b1, '0, 1'b0, 3'b001);
    repeat (4)  step(1'b1, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    repeat (1500) step(1'b1, K'($urandom), 1'b0, '0);
    repeat (1500) begin
      r = $urandom_range(0, 99);
      step(r != 0, K'($urandom), $urandom_range(0, 29) == 0,
           ($urandom_range(0, 29) == 0) ? K'($urandom) : '0);
    end
    repeat (3) step(1'b1, '0, 1'b0, '0);
    done = 1'b1;
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
